// File: rtl/dmem_sync_responder_if.sv
// Load/store port between the core's RAM controller (master) and the data memory (slave).
// Carries the sampled request fields and the registered response.
interface dmem_sync_responder_if;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_we;
  logic [2:0]  i_mode;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_err_sticky;

  modport master (
    output i_addr, i_wdata, i_we, i_mode,
    input  o_rdata, o_misaligned, o_err_sticky
  );

  modport slave (
    input  i_addr, i_wdata, i_we, i_mode,
    output o_rdata, o_misaligned, o_err_sticky
  );
endinterface

// File: rtl/dmem_sync_responder.sv
// Synchronous byte-lane data memory with 1-cycle registered, extended load data.
// Misaligned accesses are flagged and have no effect on memory contents.
module dmem_sync_responder #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    ADDR_W      = 10,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_sync_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    DM_LB  = 3'd0,
    DM_LH  = 3'd1,
    DM_LW  = 3'd2,
    DM_LBU = 3'd3,
    DM_LHU = 3'd4,
    DM_SB  = 3'd5,
    DM_SH  = 3'd6,
    DM_SW  = 3'd7
  } dm_mode_e;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;
  logic        r_misaligned;
  logic        r_err_sticky;

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_off;
  dm_mode_e          w_mode;
  logic [31:0]       w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;
  logic [31:0]       w_wbus;
  logic [3:0]        w_lanes;
  logic              w_is_store;
  logic              w_misaligned;
  logic              w_wr_en;
  logic              w_unused_addr;

  assign w_idx         = bus.i_addr[ADDR_W+1:2];
  assign w_off         = bus.i_addr[1:0];
  assign w_mode        = dm_mode_e'(bus.i_mode);
  assign w_word        = r_mem[w_idx];
  assign w_byte        = w_word[{w_off, 3'b000} +: 8];
  assign w_half        = w_off[1] ? w_word[31:16] : w_word[15:0];
  assign w_unused_addr = ^bus.i_addr[31:ADDR_W+2];

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_ext        = w_word;
    w_wbus       = bus.i_wdata;
    w_lanes      = 4'b0000;
    w_is_store   = 1'b0;
    w_misaligned = 1'b0;
    case (w_mode)
      DM_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
      DM_LBU: w_ext = {24'd0, w_byte};
      DM_LH: begin
        w_misaligned = w_off[0];
        w_ext        = {{16{w_half[15]}}, w_half};
      end
      DM_LHU: begin
        w_misaligned = w_off[0];
        w_ext        = {16'd0, w_half};
      end
      DM_SB: begin
        w_is_store = 1'b1;
        w_lanes    = 4'b0001 << w_off;
        w_wbus     = {4{bus.i_wdata[7:0]}};
      end
      DM_SH: begin
        w_is_store   = 1'b1;
        w_misaligned = w_off[0];
        w_lanes      = w_off[1] ? 4'b1100 : 4'b0011;
        w_wbus       = {2{bus.i_wdata[15:0]}};
      end
      DM_SW: begin
        w_is_store   = 1'b1;
        w_misaligned = |w_off;
        w_lanes      = 4'b1111;
      end
      default: w_misaligned = |w_off;  // LW and any undefined code
    endcase
  end

  assign w_wr_en = bus.i_we && w_is_store && !w_misaligned && !rst;

  // NOTE: the array has no reset; contents survive rst, only the write is gated.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (w_lanes[k]) r_mem[w_idx][8*k +: 8] <= w_wbus[8*k +: 8];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata      <= 32'd0;
      r_misaligned <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_rdata      <= w_misaligned ? 32'd0 : w_ext;
      r_misaligned <= w_misaligned;
      if (w_misaligned) r_err_sticky <= 1'b1;
    end
  end

  assign bus.o_rdata      = r_rdata;
  assign bus.o_misaligned = r_misaligned;
  assign bus.o_err_sticky = r_err_sticky;

endmodule

// File: tb/tb_dmem_sync_responder.sv
// Scoreboard bench for dmem_sync_responder: stimulus queues expected responses,
// a monitor compares them one cycle after each issued access.
module tb_dmem_sync_responder;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                         LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] rdata;
    bit          care;
    bit          mis;
    bit          sticky;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   issue_flag = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  dmem_sync_responder_if bus ();

  dmem_sync_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(10), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input string name, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic we, input logic [31:0] rd,
                       input bit care, input bit mis, input bit sticky);
    exp_t e;
    @(negedge clk);
    rst            = 1'b0;
    bus.i_mode     = mode;
    bus.i_addr     = addr;
    bus.i_wdata    = wdata;
    bus.i_we       = we;
    issue_flag     = 1'b1;
    e.rdata = rd; e.care = care; e.mis = mis; e.sticky = sticky; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.i_mode  = LW;
    bus.i_addr  = 32'd0;
    bus.i_wdata = 32'd0;
    bus.i_we    = 1'b0;
    issue_flag  = 1'b0;
  endtask

  // Monitor: an access issued before an edge is answered right after that edge.
  initial begin
    forever begin : mon
      bit   pend;
      exp_t e;
      @(posedge clk);
      pend = issue_flag;
      #1;
      if (pend) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          if (e.care) check({e.name, "_rdata"}, bus.o_rdata, e.rdata);
          check({e.name, "_mis"},    {31'd0, bus.o_misaligned}, {31'd0, e.mis});
          check({e.name, "_sticky"}, {31'd0, bus.o_err_sticky}, {31'd0, e.sticky});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.i_mode  = LW;
    bus.i_addr  = 32'd0;
    bus.i_wdata = 32'd0;
    bus.i_we    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata",  bus.o_rdata, 32'd0);
    check("rst_mis",    {31'd0, bus.o_misaligned}, 32'd0);
    check("rst_sticky", {31'd0, bus.o_err_sticky}, 32'd0);

    // Basic store/load and extensions
    issue("sw10",    SW,  32'h10, 32'hDEADBEEF, 1'b1, 32'h0,        0, 0, 0);
    issue("lw10",    LW,  32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1, 0, 0);
    issue("lb13",    LB,  32'h13, 32'h0,        1'b0, 32'hFFFFFFDE, 1, 0, 0);
    issue("lbu13",   LBU, 32'h13, 32'h0,        1'b0, 32'h000000DE, 1, 0, 0);
    issue("lh10",    LH,  32'h10, 32'h0,        1'b0, 32'hFFFFBEEF, 1, 0, 0);
    issue("lhu12",   LHU, 32'h12, 32'h0,        1'b0, 32'h0000DEAD, 1, 0, 0);
    issue("lb10",    LB,  32'h10, 32'h0,        1'b0, 32'hFFFFFFEF, 1, 0, 0);

    // Partial stores; store-mode read returns the pre-write word unextended
    issue("sb11",    SB,  32'h11, 32'hFFFFFF55, 1'b1, 32'hDEADBEEF, 1, 0, 0);
    issue("lw10_sb", LW,  32'h10, 32'h0,        1'b0, 32'hDEAD55EF, 1, 0, 0);
    issue("sh12",    SH,  32'h12, 32'hABCD1234, 1'b1, 32'hDEAD55EF, 1, 0, 0);
    issue("lw10_sh", LW,  32'h10, 32'h0,        1'b0, 32'h123455EF, 1, 0, 0);

    // Misaligned accesses
    issue("sw20",    SW,  32'h20, 32'h0F0F0F0F, 1'b1, 32'h0,        0, 0, 0);
    issue("sw22_mis",SW,  32'h22, 32'hCAFEF00D, 1'b1, 32'h0,        0, 1, 1);
    issue("lw20_a",  LW,  32'h20, 32'h0,        1'b0, 32'h0F0F0F0F, 1, 0, 1);
    issue("sh21_mis",SH,  32'h21, 32'hFFFFFFFF, 1'b1, 32'h0,        0, 1, 1);
    issue("lw23_mis",LW,  32'h23, 32'h0,        1'b0, 32'h0,        1, 1, 1);
    issue("lhu21_mis",LHU,32'h21, 32'h0,        1'b0, 32'h0,        1, 1, 1);
    issue("lw20_b",  LW,  32'h20, 32'h0,        1'b0, 32'h0F0F0F0F, 1, 0, 1);
    issue("lbu23",   LBU, 32'h23, 32'h0,        1'b0, 32'h0000000F, 1, 0, 1);

    // Read-during-write and load mode with i_we high
    issue("sw30_a",  SW,  32'h30, 32'hAAAAAAAA, 1'b1, 32'h0,        0, 0, 1);
    issue("sw30_b",  SW,  32'h30, 32'h11111111, 1'b1, 32'hAAAAAAAA, 1, 0, 1);
    issue("lw30",    LW,  32'h30, 32'h0,        1'b0, 32'h11111111, 1, 0, 1);
    issue("lh30_we", LH,  32'h30, 32'h22222222, 1'b1, 32'h00001111, 1, 0, 1);
    issue("lw30_b",  LW,  32'h30, 32'h0,        1'b0, 32'h11111111, 1, 0, 1);

    // Address aliasing modulo DEPTH*4
    issue("lw_alias",LW,  32'h10 + DEPTH*4, 32'h0, 1'b0, 32'h123455EF, 1, 0, 1);
    issue("sb_alias",SB,  32'h12 + DEPTH*4, 32'h00000099, 1'b1, 32'h123455EF, 1, 0, 1);
    issue("lw10_al", LW,  32'h10, 32'h0,        1'b0, 32'h129955EF, 1, 0, 1);

    // Reset with a store presented in the same cycle
    issue("sw40",    SW,  32'h40, 32'h0BADF00D, 1'b1, 32'h0,        0, 0, 1);
    @(negedge clk);
    rst         = 1'b1;
    bus.i_mode  = SW;
    bus.i_addr  = 32'h40;
    bus.i_wdata = 32'h77777777;
    bus.i_we    = 1'b1;
    issue_flag  = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_rdata",  bus.o_rdata, 32'd0);
    check("rst2_mis",    {31'd0, bus.o_misaligned}, 32'd0);
    check("rst2_sticky", {31'd0, bus.o_err_sticky}, 32'd0);
    issue("lw40",    LW,  32'h40, 32'h0,        1'b0, 32'h0BADF00D, 1, 0, 0);
    issue("lw10_rst",LW,  32'h10, 32'h0,        1'b0, 32'h129955EF, 1, 0, 0);

    idle();
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
